branch_resolve: RTL and testbench
=================================

# branch_resolve

Execute-stage control-flow resolver: the producer side of the fetch redirect interface (`npc_control` / `branch_pc`). It computes the architecturally correct next PC of each valid EX-stage instruction and compares it with the PC the fetch stage actually followed, which is the static prediction carried down the pipe. On a mismatch it issues a one-cycle redirect. It then kills the two wrong-path instructions behind the redirect and latches a sticky halt when an illegal-opcode instruction commits. It also keeps saturating branch and mispredict statistics counters.

## Interface
- `CNT_W`, 16, width of the statistics counters.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset: synchronous, active-low.
- `ex_valid`  in  1  EX slot holds an instruction.
- `ex_opcode`  in  7  opcode (the codebase opcode defines).
- `ex_funct3`  in  3  branch condition.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_pred_pc`  in  32  next PC fetch actually used after `ex_pc`.
- `ex_rs1`, `ex_rs2`  in  32 each  forwarded operand values.
- `ex_imm`  in  32  sign-extended immediate.
- `ex_halt`  in  1  fetch-stage halt flag carried with the instruction.
- `npc_control`  out  1  redirect fetch this cycle.
- `branch_pc`  out  32  redirect target (actual next PC).
- `squash`  out  1  current EX instruction is wrong-path; downstream drops its side effects.
- `halted`  out  1  sticky: a non-squashed halt instruction reached EX.
- `branch_cnt`  out  CNT_W  resolved B_TYPE/JAL/JALR count.
- `mispredict_cnt`  out  CNT_W  redirects issued.

## Operation
- Actual next PC (`branch_pc`, combinational):
  - B_TYPE: taken gives `ex_pc+ex_imm`; not taken gives `ex_pc+4`.
  - funct3 conditions: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE. Codes 010/011 are treated as not taken.
  - J_JAL: `ex_pc+ex_imm`.
  - I_JALR: `(ex_rs1+ex_imm) & ~1`.
  - All other opcodes: `ex_pc+4`.
  - All additions are 32-bit modulo; wrap past 0xFFFFFFFC is not detected.
- An instruction is live when `ex_valid` = 1, state = RUN, and `rst` = 1.
- `npc_control` = live AND !`ex_halt` AND (actual != `ex_pred_pc`). It is combinational, so fetch samples it at the negedge of the same cycle.
- State machine states: RUN, SH2, SH1, HALT.
  - RUN, live with `ex_halt`: go to HALT. No redirect, no counting.
  - RUN, `npc_control`: go to SH2.
  - RUN, otherwise: stay in RUN.
  - SH2 goes to SH1, and SH1 goes to RUN, unconditionally. Inputs in these states are ignored.
  - HALT is held until reset.
- `squash` = 1 in SH2 and SH1, else 0. In HALT, `squash` = 1 whenever `ex_valid` = 1.
- `halted` = 1 exactly in HALT.
- `branch_cnt` increments on a live non-halt B_TYPE/JAL/JALR.
- `mispredict_cnt` increments when `npc_control` = 1.
- Both counters saturate at all-ones and never wrap.

## Timing
- Reset (`rst` = 0 sampled at posedge):
  - State RUN, counters 0, `halted` 0.
  - While `rst` = 0: `npc_control` 0, `squash` 0, `branch_pc` 0.
  - Reset mid-shadow or in HALT returns to RUN on the next cycle with no residual squash.
- Redirect latency: 0 cycles.
  - Mispredict in cycle N gives `npc_control` = 1 in N only.
  - `squash` = 1 in N+1 and N+2.
  - The first correct-path instruction is resolvable in N+3.
- Counter and state updates are visible the cycle after the event.
- Simultaneous events:
  - A mispredicting instruction that also has `ex_halt` halts and does not redirect.
  - A mispredict arriving in SH2/SH1 is suppressed and not counted.
  - `ex_valid` = 0 in RUN causes no change.
- A correct prediction gives `npc_control` 0 and counts the branch only.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with a live mispredicting JAL on the inputs -> `npc_control`, `squash`, `halted`, both counters, and `branch_pc` all 0.
- BEQ not taken, mispredicted:
  - Stimulus: `ex_pc`=0x100, rs1=5, rs2=6, imm=0x20, pred=0x120.
  - Response: `npc_control`=1 and `branch_pc`=0x104 for one cycle; `squash`=1 for the next two cycles; `mispredict_cnt`=1, `branch_cnt`=1.
  - Wrong-path mispredicts presented during the squash window cause no redirect.
- Correct predictions:
  - BLTU with rs1=1, rs2=0xFFFFFFFF, pc=0x40, imm=-8, pred=0x38 -> no redirect, `branch_cnt`+1.
  - BLT with rs1=0xFFFFFFFF, rs2=1 (signed -1 < 1), pc=0x40, imm=0x10, pred=0x50 -> taken, no redirect.
- JALR: rs1=0x1003, imm=0x4, pred=0x8 -> `branch_pc`=0x1006, `npc_control`=1.
- Halt:
  - Live `ex_halt`=1 with an opcode whose actual PC differs from `ex_pred_pc` -> no redirect.
  - `halted`=1 from the next cycle and held for 10 cycles; `squash`=1 for every later valid instruction.
  - `rst`=0 for one cycle clears `halted`.
- Saturation: preload via 2^CNT_W−1 mispredicts (CNT_W=4: 15) then one more -> `mispredict_cnt` stays 15.

Source files
------------

// File: rtl/branch_resolve.sv
// EX-stage branch resolver: redirects fetch on a next-PC mispredict, kills two shadow slots, latches halt.
// Latency: npc_control/branch_pc combinational (0 cycles); state and counters visible next cycle; no backpressure.
module branch_resolve #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_pred_pc,
  input  logic [31:0]      ex_rs1,
  input  logic [31:0]      ex_rs2,
  input  logic [31:0]      ex_imm,
  input  logic             ex_halt,
  output logic             npc_control,
  output logic [31:0]      branch_pc,
  output logic             squash,
  output logic             halted,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam logic [6:0] OP_B_TYPE = 7'b1100011;
  localparam logic [6:0] OP_J_JAL  = 7'b1101111;
  localparam logic [6:0] OP_I_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SH2  = 2'd1,
    ST_SH1  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic        taken;
  logic        is_cf;
  logic        live;
  logic        mispredict;
  logic [31:0] actual_pc;

  always_comb begin
    taken = 1'b0;
    unique case (ex_funct3)
      3'b000:  taken = (ex_rs1 == ex_rs2);
      3'b001:  taken = (ex_rs1 != ex_rs2);
      3'b100:  taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  taken = (ex_rs1 <  ex_rs2);
      3'b111:  taken = (ex_rs1 >= ex_rs2);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    actual_pc = ex_pc + 32'd4;
    is_cf     = 1'b0;
    case (ex_opcode)
      OP_B_TYPE: begin
        is_cf     = 1'b1;
        actual_pc = taken ? (ex_pc + ex_imm) : (ex_pc + 32'd4);
      end
      OP_J_JAL: begin
        is_cf     = 1'b1;
        actual_pc = ex_pc + ex_imm;
      end
      OP_I_JALR: begin
        is_cf     = 1'b1;
        actual_pc = (ex_rs1 + ex_imm) & ~32'd1;
      end
      default: begin
        is_cf     = 1'b0;
        actual_pc = ex_pc + 32'd4;
      end
    endcase
  end

  // Only RUN resolves; shadow and halt slots never redirect or count.
  assign live       = rst && ex_valid && (state_q == ST_RUN);
  assign mispredict = live && !ex_halt && (actual_pc != ex_pred_pc);

  assign npc_control    = mispredict;
  assign branch_pc      = rst ? actual_pc : 32'd0;
  assign halted         = (state_q == ST_HALT);
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

  always_comb begin
    state_d = state_q;
    squash  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (live && ex_halt) begin
          state_d = ST_HALT;
        end else if (mispredict) begin
          state_d = ST_SH2;
        end
      end
      ST_SH2: begin
        state_d = ST_SH1;
        squash  = rst;
      end
      ST_SH1: begin
        state_d = ST_RUN;
        squash  = rst;
      end
      ST_HALT: begin
        state_d = ST_HALT;
        squash  = rst && ex_valid;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (live && !ex_halt && is_cf && (branch_cnt_q != {CNT_W{1'b1}})) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispredict && (mispredict_cnt_q != {CNT_W{1'b1}})) begin
      mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= ST_RUN;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: vector table, hand sequences for shadow/halt/saturation, random vs. reference model.
module tb_branch_resolve;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid;
  logic [6:0]       ex_opcode;
  logic [2:0]       ex_funct3;
  logic [31:0]      ex_pc, ex_pred_pc, ex_rs1, ex_rs2, ex_imm;
  logic             ex_halt;
  logic             npc_control;
  logic [31:0]      branch_pc;
  logic             squash;
  logic             halted;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  branch_resolve #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_pred_pc(ex_pred_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_halt(ex_halt),
    .npc_control(npc_control), .branch_pc(branch_pc), .squash(squash),
    .halted(halted), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: remaining shadow slots, halt flag, plain integer counters.
  int m_kill = 0;
  bit m_halt = 1'b0;
  int m_bc   = 0;
  int m_mc   = 0;

  logic        cap_npc;
  logic        cap_sq;
  logic [31:0] cap_bpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_next(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [31:0] pc, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm);
    bit t;
    if (op == OP_JAL) return pc + imm;
    if (op == OP_JR) return (a + imm) & 32'hFFFF_FFFE;
    if (op != OP_B) return pc + 32'd4;
    case (f3)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = (int'(a) < int'(b));
      3'd5: t = (int'(a) >= int'(b));
      3'd6: t = (a < b);
      3'd7: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t ? pc + imm : pc + 32'd4;
  endfunction

  function automatic bit is_cf(input logic [6:0] op);
    return (op == OP_B) || (op == OP_JAL) || (op == OP_JR);
  endfunction

  // Applies one cycle of inputs, checks every output against the model, then advances the model.
  task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic [31:0] pc, input logic [31:0] pred, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, input logic h, input logic rn);
    logic [31:0] nxt;
    bit live, e_npc, e_sq;
    ex_valid = v; ex_opcode = op; ex_funct3 = f3; ex_pc = pc; ex_pred_pc = pred;
    ex_rs1 = a; ex_rs2 = b; ex_imm = imm; ex_halt = h; rst = rn;
    nxt   = ref_next(op, f3, pc, a, b, imm);
    live  = rn && v && !m_halt && (m_kill == 0);
    e_npc = live && !h && (nxt != pred);
    e_sq  = rn && ((m_kill > 0) || (m_halt && v));
    @(negedge clk);
    cap_npc = npc_control;
    cap_bpc = branch_pc;
    cap_sq  = squash;
    chk("npc_control", 32'(npc_control), 32'(e_npc));
    chk("branch_pc", branch_pc, rn ? nxt : 32'd0);
    chk("squash", 32'(squash), 32'(e_sq));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("branch_cnt", 32'(branch_cnt), 32'(m_bc));
    chk("mispredict_cnt", 32'(mispredict_cnt), 32'(m_mc));
    @(posedge clk);
    if (!rn) begin
      m_kill = 0; m_halt = 1'b0; m_bc = 0; m_mc = 0;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (m_kill > 0) begin
      m_kill--;
    end else if (live) begin
      if (h) begin
        m_halt = 1'b1;
      end else begin
        if (is_cf(op) && m_bc < SAT) m_bc++;
        if (e_npc) begin
          if (m_mc < SAT) m_mc++;
          m_kill = 2;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, OP_ALU, 3'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, OP_ALU, 3'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, pred, rs1, rs2, imm;
    logic        e_npc;
    logic [31:0] e_bpc;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [6:0] ops[6];
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] pc, a, b, imm, pred;
    logic v, h, rn;

    vt[0]  = '{OP_B,   3'd0, 32'h100,        32'h120,     32'd5,         32'd6,         32'h20,        1'b1, 32'h104};
    vt[1]  = '{OP_B,   3'd6, 32'h40,         32'h38,      32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b0, 32'h38};
    vt[2]  = '{OP_B,   3'd4, 32'h40,         32'h50,      32'hFFFF_FFFF, 32'd1,         32'h10,        1'b0, 32'h50};
    vt[3]  = '{OP_JR,  3'd0, 32'h200,        32'h8,       32'h1003,      32'd0,         32'h4,         1'b1, 32'h1006};
    vt[4]  = '{OP_JAL, 3'd0, 32'h300,        32'h304,     32'd0,         32'd0,         32'h40,        1'b1, 32'h340};
    vt[5]  = '{OP_B,   3'd1, 32'h10,         32'h14,      32'd7,         32'd7,         32'h10,        1'b0, 32'h14};
    vt[6]  = '{OP_B,   3'd5, 32'h20,         32'h28,      32'h8000_0000, 32'd0,         32'h8,         1'b1, 32'h24};
    vt[7]  = '{OP_B,   3'd7, 32'h20,         32'h28,      32'h8000_0000, 32'd0,         32'h8,         1'b0, 32'h28};
    vt[8]  = '{OP_B,   3'd2, 32'h60,         32'h70,      32'd3,         32'd3,         32'h10,        1'b1, 32'h64};
    vt[9]  = '{OP_ALU, 3'd0, 32'hFFFF_FFFC,  32'h0,       32'd1,         32'd2,         32'h0,         1'b0, 32'h0};
    vt[10] = '{OP_JAL, 3'd0, 32'hFFFF_FFF0,  32'h0,       32'd0,         32'd0,         32'h20,        1'b1, 32'h10};
    vt[11] = '{OP_B,   3'd0, 32'h80,         32'h84,      32'd3,         32'd3,         32'hFFFF_FFF0, 1'b1, 32'h70};

    ops[0] = OP_B; ops[1] = OP_JAL; ops[2] = OP_JR; ops[3] = OP_ALU; ops[4] = OP_IMM; ops[5] = OP_LD;

    rst = 1'b0; ex_valid = 1'b0; ex_opcode = OP_ALU; ex_funct3 = 3'd0; ex_pc = 32'd0;
    ex_pred_pc = 32'd0; ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_imm = 32'd0; ex_halt = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with a live mispredicting JAL on the inputs.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, OP_JAL, 3'd0, 32'h100, 32'h104, 32'd0, 32'd0, 32'h40, 1'b0, 1'b0);
      chk("reset npc", 32'(cap_npc), 32'd0);
      chk("reset bpc", cap_bpc, 32'd0);
    end

    // BEQ mispredict, then wrong-path mispredicts inside the shadow.
    step(1'b1, OP_B, 3'd0, 32'h100, 32'h120, 32'd5, 32'd6, 32'h20, 1'b0, 1'b1);
    chk("beq npc", 32'(cap_npc), 32'd1);
    chk("beq bpc", cap_bpc, 32'h104);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, OP_JAL, 3'd0, 32'h120, 32'h124, 32'd0, 32'd0, 32'h80, 1'b0, 1'b1);
      chk("shadow npc", 32'(cap_npc), 32'd0);
      chk("shadow squash", 32'(cap_sq), 32'd1);
    end
    chk("beq mispredict_cnt", 32'(mispredict_cnt), 32'd1);
    chk("beq branch_cnt", 32'(branch_cnt), 32'd1);
    step(1'b1, OP_ALU, 3'd0, 32'h104, 32'h108, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("post-shadow squash", 32'(cap_sq), 32'd0);

    // Vector table; two idle slots after each let any shadow drain.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vt[i].op, vt[i].f3, vt[i].pc, vt[i].pred, vt[i].rs1, vt[i].rs2, vt[i].imm, 1'b0, 1'b1);
      chk($sformatf("tbl%0d npc", i), 32'(cap_npc), 32'(vt[i].e_npc));
      chk($sformatf("tbl%0d bpc", i), cap_bpc, vt[i].e_bpc);
      idle();
      idle();
    end

    // Halt on an instruction that would otherwise mispredict.
    do_reset();
    step(1'b1, OP_JAL, 3'd0, 32'h500, 32'h504, 32'd0, 32'd0, 32'h100, 1'b1, 1'b1);
    chk("halt npc", 32'(cap_npc), 32'd0);
    for (int i = 0; i < 10; i++) begin
      v = 1'($urandom_range(0, 1));
      step(v, OP_JAL, 3'd0, 32'h504, 32'h508, 32'd0, 32'd0, 32'h40, 1'b0, 1'b1);
      chk("halt hold", 32'(halted), 32'd1);
      chk("halt squash", 32'(cap_sq), 32'(v));
    end
    do_reset();
    chk("halt cleared", 32'(halted), 32'd0);
    step(1'b1, OP_ALU, 3'd0, 32'h600, 32'h604, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("no residual squash", 32'(cap_sq), 32'd0);

    // Saturation: 16 mispredicting jumps against a 4-bit counter.
    do_reset();
    for (int i = 0; i < SAT + 1; i++) begin
      step(1'b1, OP_JAL, 3'd0, 32'h700, 32'h704, 32'd0, 32'd0, 32'h40, 1'b0, 1'b1);
      idle();
      idle();
    end
    chk("sat mispredict_cnt", 32'(mispredict_cnt), SAT);
    chk("sat branch_cnt", 32'(branch_cnt), SAT);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      op   = ops[$urandom_range(0, 5)];
      f3   = 3'($urandom_range(0, 7));
      pc   = $urandom & 32'hFFFF_FFFC;
      a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm  = 32'(signed'(12'($urandom)));
      pred = ($urandom_range(0, 2) != 0) ? ref_next(op, f3, pc, a, b, imm) : (pc + 32'd4);
      v    = ($urandom_range(0, 4) != 0);
      h    = ($urandom_range(0, 63) == 0);
      rn   = ($urandom_range(0, 49) != 0);
      step(v, op, f3, pc, pred, a, b, imm, h, rn);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
